// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: button-driven time/date set controller for the watch_date counter.
// Captures the running time into a shadow register and edits it one field at a time.
// It then loads the edited value into the counter with a one-cycle set_time strobe.
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   clk1sec         - one-clk pulse per second (timeout and blink timebase)
//   btn_mode/next/up/down - debounced single-cycle button pulses
//   cur_time[37:0]  - running time {year,month,day,hour,minute,second}
//   set_time        - one-cycle load strobe to the counter
//   bin_time[37:0]  - committed value, valid while set_time=1
//   editing         - high while a field is being edited
//   edit_field[2:0] - 0=none, 1=year .. 6=second
//   blink           - toggles each second while editing
//   display_time    - shadow while editing, otherwise cur_time
module watch_set_ctrl #(
    parameter int unsigned TIMEOUT_SEC = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk1sec,
    input  logic        btn_mode,
    input  logic        btn_next,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [37:0] cur_time,
    output logic        set_time,
    output logic [37:0] bin_time,
    output logic        editing,
    output logic [2:0]  edit_field,
    output logic        blink,
    output logic [37:0] display_time
);

    // Timeout counter width; kept at 1 bit when the timeout is disabled.
    localparam int unsigned TW    = (TIMEOUT_SEC > 0) ? $clog2(TIMEOUT_SEC + 1) : 1;
    localparam int unsigned TLAST = (TIMEOUT_SEC > 0) ? TIMEOUT_SEC - 1 : 0;

    typedef struct packed {
        logic [11:0] year;
        logic [3:0]  month;
        logic [4:0]  day;
        logic [4:0]  hour;
        logic [5:0]  minute;
        logic [5:0]  second;
    } wtime_t;

    // Edit states carry their edit_field code as the encoding.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        E_YEAR  = 3'd1,
        E_MONTH = 3'd2,
        E_DAY   = 3'd3,
        E_HOUR  = 3'd4,
        E_MIN   = 3'd5,
        E_SEC   = 3'd6,
        COMMIT  = 3'd7
    } state_t;

    state_t        state, state_next;
    wtime_t        shadow, shadow_next;
    logic [TW-1:0] tcnt, tcnt_next;
    logic          set_next, editing_next, blink_next, any_btn;
    logic [2:0]    field_next;
    logic [37:0]   bin_next;

    // Days in month, no leap years (matches the counter).
    function automatic logic [4:0] max_date(input logic [3:0] m);
        case (m)
            4'd2:                      max_date = 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   max_date = 5'd30;
            default:                   max_date = 5'd31;
        endcase
    endfunction

    // Force a captured time into legal ranges before editing.
    function automatic wtime_t sanitize(input wtime_t t);
        wtime_t s;
        s = t;
        if (t.month == 4'd0 || t.month > 4'd12) s.month = 4'd1;
        if (t.day == 5'd0)                      s.day = 5'd1;
        else if (t.day > max_date(s.month))     s.day = max_date(s.month);
        if (t.hour > 5'd23)                     s.hour = 5'd0;
        if (t.minute > 6'd59)                   s.minute = 6'd0;
        if (t.second > 6'd59)                   s.second = 6'd0;
        return s;
    endfunction

    // Increment/decrement one field with wrap; month changes re-clamp the day.
    function automatic wtime_t step_field(input wtime_t t, input state_t f, input logic up);
        wtime_t     r;
        logic [4:0] md;
        r  = t;
        md = max_date(t.month);
        case (f)
            E_YEAR:  r.year = up ? t.year + 12'd1 : t.year - 12'd1;
            E_MONTH: begin
                if (up) r.month = (t.month >= 4'd12) ? 4'd1 : t.month + 4'd1;
                else    r.month = (t.month <= 4'd1) ? 4'd12 : t.month - 4'd1;
                md = max_date(r.month);
                if (t.day > md) r.day = md;
            end
            E_DAY: begin
                if (up) r.day = (t.day >= md) ? 5'd1 : t.day + 5'd1;
                else    r.day = (t.day <= 5'd1) ? md : t.day - 5'd1;
            end
            E_HOUR: begin
                if (up) r.hour = (t.hour >= 5'd23) ? 5'd0 : t.hour + 5'd1;
                else    r.hour = (t.hour == 5'd0) ? 5'd23 : t.hour - 5'd1;
            end
            E_MIN: begin
                if (up) r.minute = (t.minute >= 6'd59) ? 6'd0 : t.minute + 6'd1;
                else    r.minute = (t.minute == 6'd0) ? 6'd59 : t.minute - 6'd1;
            end
            E_SEC: begin
                if (up) r.second = (t.second >= 6'd59) ? 6'd0 : t.second + 6'd1;
                else    r.second = (t.second == 6'd0) ? 6'd59 : t.second - 6'd1;
            end
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic is_edit(input state_t s);
        return (s != IDLE) && (s != COMMIT);
    endfunction

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shadow     <= '0;
            tcnt       <= '0;
            set_time   <= 1'b0;
            bin_time   <= '0;
            editing    <= 1'b0;
            edit_field <= 3'd0;
            blink      <= 1'b0;
        end else begin
            state      <= state_next;
            shadow     <= shadow_next;
            tcnt       <= tcnt_next;
            set_time   <= set_next;
            bin_time   <= bin_next;
            editing    <= editing_next;
            edit_field <= field_next;
            blink      <= blink_next;
        end
    end

    // Next state, shadow edits, timeout and output next-values.
    always_comb begin
        state_next  = state;
        shadow_next = shadow;
        tcnt_next   = tcnt;
        any_btn     = btn_mode | btn_next | btn_up | btn_down;

        case (state)
            IDLE: begin
                if (btn_mode) begin
                    shadow_next = sanitize(wtime_t'(cur_time));
                    state_next  = E_YEAR;
                    tcnt_next   = '0;
                end
            end
            COMMIT: state_next = IDLE;
            default: begin
                if (btn_mode) begin
                    state_next = IDLE;
                end else if (btn_next) begin
                    case (state)
                        E_YEAR:  state_next = E_MONTH;
                        E_MONTH: state_next = E_DAY;
                        E_DAY:   state_next = E_HOUR;
                        E_HOUR:  state_next = E_MIN;
                        E_MIN:   state_next = E_SEC;
                        default: state_next = COMMIT;
                    endcase
                end else if (btn_up || btn_down) begin
                    shadow_next = step_field(shadow, state, btn_up);
                end

                // A button press wins over a coincident second tick.
                if (any_btn) begin
                    tcnt_next = '0;
                end else if (clk1sec && (TIMEOUT_SEC > 0)) begin
                    if (tcnt == TW'(TLAST)) begin
                        state_next = IDLE;
                        tcnt_next  = '0;
                    end else begin
                        tcnt_next = tcnt + TW'(1);
                    end
                end
            end
        endcase

        set_next     = (state_next == COMMIT);
        bin_next     = set_next ? shadow : bin_time;
        editing_next = is_edit(state_next);
        field_next   = editing_next ? state_next : 3'd0;
        if (!editing_next || state == IDLE) blink_next = 1'b0;
        else                                blink_next = clk1sec ? ~blink : blink;
    end

    assign display_time = editing ? shadow : cur_time;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Self-checking bench for watch_set_ctrl: directed scenarios plus random buttons,
// all compared cycle by cycle against a field-level behavioural model.
module tb_watch_set_ctrl;
    localparam int unsigned TO = 3;

    logic        clk = 1'b0;
    logic        rst, clk1sec, btn_mode, btn_next, btn_up, btn_down;
    logic [37:0] cur_time;
    logic        set_time, editing, blink;
    logic [37:0] bin_time, display_time;
    logic [2:0]  edit_field;

    int errors = 0;
    int checks = 0;
    int set_pulses = 0;

    // Model: m_fld 0=idle, 1..6=editing field, 7=commit cycle.
    int          m_fld = 0;
    int          m_cnt = 0;
    bit          m_blk = 1'b0;
    int          sh[6] = '{default: 0};
    logic [37:0] m_bt = '0;

    always #5 clk = ~clk;

    watch_set_ctrl #(.TIMEOUT_SEC(TO)) dut (
        .clk(clk), .rst(rst), .clk1sec(clk1sec),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down),
        .cur_time(cur_time), .set_time(set_time), .bin_time(bin_time),
        .editing(editing), .edit_field(edit_field), .blink(blink),
        .display_time(display_time)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mdays(input int m);
        case (m)
            2:             return 28;
            4, 6, 9, 11:   return 30;
            default:       return 31;
        endcase
    endfunction

    function automatic logic [37:0] pack(input int y, mo, d, h, mi, s);
        return {12'(y), 4'(mo), 5'(d), 5'(h), 6'(mi), 6'(s)};
    endfunction

    function automatic logic [37:0] pack_sh();
        return pack(sh[0], sh[1], sh[2], sh[3], sh[4], sh[5]);
    endfunction

    task automatic bump(input int f, input int dl);
        int md;
        case (f)
            1: sh[0] = (sh[0] + dl + 4096) % 4096;
            2: begin
                sh[1] = ((sh[1] - 1 + dl + 12) % 12) + 1;
                if (sh[2] > mdays(sh[1])) sh[2] = mdays(sh[1]);
            end
            3: begin
                md    = mdays(sh[1]);
                sh[2] = ((sh[2] - 1 + dl + md) % md) + 1;
            end
            4: sh[3] = (sh[3] + dl + 24) % 24;
            5: sh[4] = (sh[4] + dl + 60) % 60;
            default: sh[5] = (sh[5] + dl + 60) % 60;
        endcase
    endtask

    task automatic model_step();
        bit any;
        int md;
        if (!rst) begin
            m_fld = 0; m_cnt = 0; m_blk = 1'b0; m_bt = '0;
            foreach (sh[i]) sh[i] = 0;
            return;
        end
        any = btn_mode | btn_next | btn_up | btn_down;
        if (m_fld == 0) begin
            if (btn_mode) begin
                sh[0] = int'(cur_time[37:26]);
                sh[1] = int'(cur_time[25:22]);
                sh[2] = int'(cur_time[21:17]);
                sh[3] = int'(cur_time[16:12]);
                sh[4] = int'(cur_time[11:6]);
                sh[5] = int'(cur_time[5:0]);
                if (sh[1] == 0 || sh[1] > 12) sh[1] = 1;
                md = mdays(sh[1]);
                if (sh[2] == 0) sh[2] = 1;
                else if (sh[2] > md) sh[2] = md;
                if (sh[3] > 23) sh[3] = 0;
                if (sh[4] > 59) sh[4] = 0;
                if (sh[5] > 59) sh[5] = 0;
                m_fld = 1; m_cnt = 0; m_blk = 1'b0;
            end
        end else if (m_fld == 7) begin
            m_fld = 0;
        end else begin
            if (clk1sec) m_blk = !m_blk;
            if (btn_mode)      m_fld = 0;
            else if (btn_next) m_fld = m_fld + 1;
            else if (btn_up)   bump(m_fld, 1);
            else if (btn_down) bump(m_fld, -1);
            if (any) m_cnt = 0;
            else if (clk1sec) begin
                m_cnt++;
                if (m_cnt >= TO) begin m_fld = 0; m_cnt = 0; end
            end
            if (m_fld < 1 || m_fld > 6) m_blk = 1'b0;
            if (m_fld == 7) m_bt = pack_sh();
        end
    endtask

    task automatic compare_all();
        bit ed;
        ed = (m_fld >= 1 && m_fld <= 6);
        check("set_time", 64'(set_time), 64'(m_fld == 7));
        check("bin_time", 64'(bin_time), 64'(m_bt));
        check("editing", 64'(editing), 64'(ed));
        check("edit_field", 64'(edit_field), ed ? 64'(m_fld) : 64'(0));
        check("blink", 64'(blink), 64'(m_blk));
        check("display_time", 64'(display_time), ed ? 64'(pack_sh()) : 64'(cur_time));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (set_time) set_pulses++;
    endtask

    task automatic press(input logic m, input logic n, input logic u, input logic d, input logic s);
        btn_mode = m; btn_next = n; btn_up = u; btn_down = d; clk1sec = s;
        tick();
        btn_mode = 0; btn_next = 0; btn_up = 0; btn_down = 0; clk1sec = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 0; clk1sec = 0; btn_mode = 0; btn_next = 0; btn_up = 0; btn_down = 0;
        cur_time = '0;
        repeat (2) tick();
        check("reset_set", 64'(set_time), 64'(0));
        check("reset_field", 64'(edit_field), 64'(0));
        rst = 1;
        tick();

        // Full edit and commit.
        cur_time = pack(2024, 3, 15, 10, 20, 30);
        press(1, 0, 0, 0, 0);
        press(0, 0, 1, 0, 0);
        repeat (6) press(0, 1, 0, 0, 0);
        check("t2_set", 64'(set_time), 64'(1));
        check("t2_bin", 64'(bin_time), 64'(pack(2025, 3, 15, 10, 20, 30)));
        press(0, 0, 0, 0, 0);
        check("t2_set_after", 64'(set_time), 64'(0));
        check("t2_edit_after", 64'(editing), 64'(0));

        // Wrap cases.
        cur_time = pack(4095, 1, 10, 0, 5, 59);
        press(1, 0, 0, 0, 0);
        press(0, 0, 1, 0, 0);
        check("wrap_year", 64'(display_time[37:26]), 64'(0));
        press(0, 1, 0, 0, 0);
        press(0, 0, 0, 1, 0);
        check("wrap_month", 64'(display_time[25:22]), 64'(12));
        press(0, 1, 0, 0, 0);
        press(0, 1, 0, 0, 0);
        press(0, 0, 0, 1, 0);
        check("wrap_hour", 64'(display_time[16:12]), 64'(23));
        press(0, 1, 0, 0, 0);
        press(0, 1, 0, 0, 0);
        press(0, 0, 1, 0, 0);
        check("wrap_second", 64'(display_time[5:0]), 64'(0));
        press(1, 0, 0, 0, 0);
        cur_time = pack(2000, 4, 1, 12, 0, 0);
        press(1, 0, 0, 0, 0);
        press(0, 1, 0, 0, 0);
        press(0, 1, 0, 0, 0);
        press(0, 0, 0, 1, 0);
        check("wrap_day_apr", 64'(display_time[21:17]), 64'(30));
        press(1, 0, 0, 0, 0);

        // Day clamp on month change.
        cur_time = pack(2000, 1, 31, 12, 0, 0);
        press(1, 0, 0, 0, 0);
        press(0, 1, 0, 0, 0);
        press(0, 0, 1, 0, 0);
        check("clamp_month", 64'(display_time[25:22]), 64'(2));
        check("clamp_day", 64'(display_time[21:17]), 64'(28));
        press(0, 0, 0, 1, 0);
        check("clamp_month_back", 64'(display_time[25:22]), 64'(1));
        check("clamp_day_stays", 64'(display_time[21:17]), 64'(28));
        press(1, 0, 0, 0, 0);

        // Priority and abort.
        cur_time = pack(2010, 6, 20, 7, 8, 9);
        press(1, 0, 0, 0, 0);
        repeat (3) press(0, 1, 0, 0, 0);
        check("prio_in_hour", 64'(edit_field), 64'(4));
        press(1, 0, 1, 0, 0);
        check("prio_abort", 64'(editing), 64'(0));
        check("prio_no_set", 64'(set_time), 64'(0));
        press(1, 0, 0, 0, 0);
        press(0, 1, 0, 1, 0);
        check("prio_next_field", 64'(edit_field), 64'(2));
        check("prio_no_dec", 64'(display_time[37:26]), 64'(2010));
        press(1, 0, 0, 0, 0);

        // Timeout and sanitize.
        cur_time = pack(2020, 0, 0, 5, 5, 5);
        press(1, 0, 0, 0, 0);
        check("san_month", 64'(display_time[25:22]), 64'(1));
        check("san_day", 64'(display_time[21:17]), 64'(1));
        check("blink_start", 64'(blink), 64'(0));
        press(0, 0, 0, 0, 1);
        check("blink_toggle", 64'(blink), 64'(1));
        press(0, 0, 0, 0, 1);
        check("to_still_edit", 64'(editing), 64'(1));
        press(0, 0, 0, 0, 1);
        check("to_abort", 64'(editing), 64'(0));
        check("to_no_set", 64'(set_time), 64'(0));
        press(1, 0, 0, 0, 0);
        press(0, 0, 0, 0, 1);
        press(0, 0, 0, 0, 1);
        press(0, 0, 1, 0, 1);
        check("to_btn_wins", 64'(editing), 64'(1));
        press(0, 0, 0, 0, 1);
        press(0, 0, 0, 0, 1);
        check("to_cleared", 64'(editing), 64'(1));
        press(0, 0, 0, 0, 1);
        check("to_abort2", 64'(editing), 64'(0));

        // Reset mid-edit.
        cur_time = pack(2024, 3, 15, 10, 20, 30);
        press(1, 0, 0, 0, 0);
        press(0, 0, 1, 0, 0);
        press(0, 0, 1, 0, 0);
        rst = 0;
        #2;
        check("rst_set", 64'(set_time), 64'(0));
        check("rst_bin", 64'(bin_time), 64'(0));
        check("rst_editing", 64'(editing), 64'(0));
        check("rst_field", 64'(edit_field), 64'(0));
        check("rst_blink", 64'(blink), 64'(0));
        set_pulses = 0;
        repeat (3) tick();
        rst = 1;
        repeat (5) tick();
        check("rst_no_set_pulse", 64'(set_pulses), 64'(0));

        // Random buttons against the model.
        for (int i = 0; i < 3000; i++) begin
            cur_time = 38'({$urandom(), $urandom()});
            btn_mode = ($urandom_range(39) == 0);
            btn_next = ($urandom_range(5) == 0);
            btn_up   = ($urandom_range(4) == 0);
            btn_down = ($urandom_range(4) == 0);
            clk1sec  = ($urandom_range(7) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
